// File: rtl/dsp_skid_buffer.sv
// dsp_skid_buffer
//   Two-entry ready/valid skid buffer behind the DSP48A1 P-output register
//   stage. Holds up to two words under consumer backpressure. in_ready,
//   out_valid, out_data and level are all registered, so no combinational
//   path runs from out_ready to in_ready.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   flush      synchronous clear of held words, active high (FLUSH_EN = 1)
//   in_data    producer word
//   in_valid   producer has a word
//   in_ready   buffer can accept a word this cycle
//   out_data   head word to the consumer
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data this cycle
//   level      words held: 0, 1 or 2
module dsp_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter bit          FLUSH_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;
  logic [DATA_WIDTH-1:0] out_data_d;
  logic [1:0]            level_d;
  logic                  in_fire;
  logic                  out_fire;
  logic                  flush_act;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign flush_act = FLUSH_EN & flush;

  always_comb begin
    state_d    = state_q;
    skid_d     = skid_q;
    out_data_d = out_data;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          out_data_d = in_data;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          out_data_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the consumer side can move
        if (out_fire) begin
          out_data_d = skid_q;
          state_d    = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // flush drops everything, including a word handshaken this cycle,
    // but leaves the last out_data visible
    if (flush_act) begin
      state_d    = ST_EMPTY;
      skid_d     = '0;
      out_data_d = out_data;
    end
  end

  always_comb begin
    level_d = 2'd0;
    unique case (state_d)
      ST_BUSY: level_d = 2'd1;
      ST_FULL: level_d = 2'd2;
      default: level_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      skid_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      level     <= 2'd0;
    end else begin
      state_q   <= state_d;
      skid_q    <= skid_d;
      out_data  <= out_data_d;
      out_valid <= (state_d != ST_EMPTY);
      in_ready  <= (state_d != ST_FULL);
      level     <= level_d;
    end
  end

endmodule

// File: tb/tb_dsp_skid_buffer.sv
// Testbench for dsp_skid_buffer: one instance with flush enabled, one with
// flush disabled, both fed the same stimulus and compared every cycle
// against a two-slot FIFO model.
module tb_dsp_skid_buffer;

  localparam int unsigned W = 48;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         out_ready;

  logic         ir [2];
  logic [W-1:0] od [2];
  logic         ov [2];
  logic [1:0]   lv [2];

  int total;
  int bad;

  dsp_skid_buffer #(.DATA_WIDTH(W), .FLUSH_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (ir[0]),
    .out_data  (od[0]),
    .out_valid (ov[0]),
    .out_ready (out_ready),
    .level     (lv[0])
  );

  dsp_skid_buffer #(.DATA_WIDTH(W), .FLUSH_EN(1'b0)) dut_nf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (ir[1]),
    .out_data  (od[1]),
    .out_valid (ov[1]),
    .out_ready (out_ready),
    .level     (lv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of up to two words per instance.
  // Index 0 is the flush-enabled instance, index 1 ignores flush.
  int unsigned  m_cnt [2];
  logic [W-1:0] m_q   [2][2];
  logic [W-1:0] m_od  [2];
  bit           m_ok;

  initial begin
    m_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_od[k]  = '0;
      m_q[k][0] = '0;
      m_q[k][1] = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int unsigned  c;
      logic [W-1:0] h0;
      logic [W-1:0] h1;
      logic [W-1:0] o;
      bit           take;
      bit           give;
      c  = m_cnt[k];
      h0 = m_q[k][0];
      h1 = m_q[k][1];
      o  = m_od[k];
      take = in_valid && (c < 2);
      give = out_ready && (c > 0);
      if (!rst) begin
        c = 0;
        o = '0;
      end else if (flush && k == 0) begin
        c = 0;
      end else begin
        if (give) begin
          h0 = h1;
          c  = c - 1;
        end
        if (take) begin
          if (c == 0) h0 = in_data;
          else        h1 = in_data;
          c = c + 1;
        end
        if (c > 0) o = h0;
      end
      m_cnt[k]  <= c;
      m_q[k][0] <= h0;
      m_q[k][1] <= h1;
      m_od[k]   <= o;
    end
    if (!rst) m_ok <= 1'b1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("out_valid[%0d]", k), 64'(ov[k]), 64'(m_cnt[k] > 0));
        chk($sformatf("in_ready[%0d]", k),  64'(ir[k]), 64'(m_cnt[k] < 2));
        chk($sformatf("level[%0d]", k),     64'(lv[k]), 64'(m_cnt[k]));
        chk($sformatf("out_data[%0d]", k),  64'(od[k]), 64'(m_od[k]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    logic [63:0] rnd;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // reset for two cycles
    step();
    step();
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_in_ready",  64'(ir[0]), 64'd1);
    chk("rst_level",     64'(lv[0]), 64'd0);
    chk("rst_out_data",  64'(od[0]), 64'd0);

    // stream 1,2,3 with consumer always ready
    rst = 1'b1;
    drive(1'b1, 48'h1, 1'b1, 1'b0);
    step();
    chk("stream1_data",  64'(od[0]), 64'h1);
    chk("stream1_level", 64'(lv[0]), 64'd1);
    drive(1'b1, 48'h2, 1'b1, 1'b0);
    step();
    chk("stream2_data",  64'(od[0]), 64'h2);
    chk("stream2_level", 64'(lv[0]), 64'd1);
    drive(1'b1, 48'h3, 1'b1, 1'b0);
    step();
    chk("stream3_data",  64'(od[0]), 64'h3);
    chk("stream3_level", 64'(lv[0]), 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("stream_end_valid", 64'(ov[0]), 64'd0);

    // stall and skid
    drive(1'b1, 48'hAAAA_AAAA_AAAA, 1'b0, 1'b0);
    step();
    chk("stall1_level", 64'(lv[0]), 64'd1);
    drive(1'b1, 48'h5555_5555_5555, 1'b0, 1'b0);
    step();
    chk("stall2_level",    64'(lv[0]), 64'd2);
    chk("stall2_in_ready", 64'(ir[0]), 64'd0);
    chk("stall2_data",     64'(od[0]), 64'hAAAA_AAAA_AAAA);
    chk("model_head",      64'(m_od[0]), 64'hAAAA_AAAA_AAAA);
    drive(1'b1, 48'h7777_7777_7777, 1'b0, 1'b0);
    step();
    chk("stall3_level", 64'(lv[0]), 64'd2);
    chk("stall3_data",  64'(od[0]), 64'hAAAA_AAAA_AAAA);

    // drain from full
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("drain1_data",  64'(od[0]), 64'h5555_5555_5555);
    chk("drain1_level", 64'(lv[0]), 64'd1);
    chk("drain1_ready", 64'(ir[0]), 64'd1);
    step();
    chk("drain2_level", 64'(lv[0]), 64'd0);
    chk("drain2_valid", 64'(ov[0]), 64'd0);
    chk("model_cnt",    64'(m_cnt[0]), 64'd0);

    // simultaneous in/out while busy
    drive(1'b1, 48'h10, 1'b0, 1'b0);
    step();
    chk("simul_pre_data", 64'(od[0]), 64'h10);
    drive(1'b1, 48'h11, 1'b1, 1'b0);
    step();
    chk("simul_data",  64'(od[0]), 64'h11);
    chk("simul_level", 64'(lv[0]), 64'd1);
    chk("simul_ready", 64'(ir[0]), 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

    // flush versus handshake, in FULL
    drive(1'b1, 48'h20, 1'b0, 1'b0);
    step();
    drive(1'b1, 48'h21, 1'b0, 1'b0);
    step();
    chk("preflush_level",    64'(lv[0]), 64'd2);
    chk("preflush_level_nf", 64'(lv[1]), 64'd2);
    drive(1'b0, '0, 1'b1, 1'b1);
    step();
    chk("flush_level",    64'(lv[0]), 64'd0);
    chk("flush_valid",    64'(ov[0]), 64'd0);
    chk("flush_ready",    64'(ir[0]), 64'd1);
    chk("flush_data",     64'(od[0]), 64'h20);
    chk("noflush_level",  64'(lv[1]), 64'd1);
    chk("noflush_data",   64'(od[1]), 64'h21);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("noflush_drained", 64'(lv[1]), 64'd0);

    // reset mid-operation from FULL with a word offered
    drive(1'b1, 48'h30, 1'b0, 1'b0);
    step();
    drive(1'b1, 48'h31, 1'b0, 1'b0);
    step();
    chk("prerst_level", 64'(lv[0]), 64'd2);
    rst = 1'b0;
    drive(1'b1, 48'h32, 1'b1, 1'b1);
    step();
    chk("midrst_valid", 64'(ov[0]), 64'd0);
    chk("midrst_data",  64'(od[0]), 64'd0);
    chk("midrst_level", 64'(lv[0]), 64'd0);
    chk("midrst_ready", 64'(ir[0]), 64'd1);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    chk("postrst_level", 64'(lv[0]), 64'd0);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      rnd       = {$urandom, $urandom};
      in_data   = rnd[W-1:0];
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_skid_buffer.md
Name: dsp_skid_buffer

Overview:
- Two-entry ready/valid skid buffer that sits between the DSP48A1 P-output pipeline register stage and a downstream consumer that can apply backpressure.
- Performs the receiving/reading side of the register stage. It accepts one word per cycle from the producer. It holds at most two words when the consumer stalls.
- It registers `in_ready`, so the backpressure path is not combinational.
- It provides a synchronous flush for pipeline restarts.

Parameters:
- DATA_WIDTH, 48, width of the data path (matches the P/PCOUT width).
- FLUSH_EN, 1, 1 = `flush` port is active; 0 = `flush` is ignored.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- flush  input  1  synchronous clear of buffered data; active-high.
- in_data  input  DATA_WIDTH  word from the producer.
- in_valid  input  1  producer has a word on `in_data`.
- in_ready  output  1  buffer can accept a word this cycle (registered).
- out_data  output  DATA_WIDTH  head word to the consumer (registered).
- out_valid  output  1  `out_data` holds a valid word (registered).
- out_ready  input  1  consumer accepts `out_data` this cycle.
- level  output  2  number of words held: 0, 1 or 2.

Behaviour:
- Handshake events:
  - Input fire = `in_valid & in_ready`.
  - Output fire = `out_valid & out_ready`.
  - Both are evaluated at the rising clk edge.
- Storage:
  - Output register (`out_data`).
  - One skid register (internal, DATA_WIDTH bits).
- States:
  - EMPTY (level 0)
  - BUSY (level 1, word in output register)
  - FULL (level 2, words in output and skid registers)
- Reset (`rst == 0` at the edge):
  - Next state is EMPTY.
  - `out_valid` = 0, `out_data` = 0, skid register = 0, `level` = 0, `in_ready` = 1.
  - While `rst` is low, `in_valid`, `out_ready` and `flush` are ignored.
  - Reset has priority over everything. Reset mid-transfer discards all held words.
- Flush (`FLUSH_EN == 1`, `flush == 1`, `rst == 1`):
  - Same result as reset, except `out_data` keeps its previous value.
  - Flush has priority over any handshake in the same cycle; that input word is dropped.
- EMPTY:
  - Input fire: `out_data` ← `in_data`, `out_valid` ← 1, go to BUSY.
  - Otherwise stay in EMPTY.
  - `out_ready` is don't-care in this state.
- BUSY:
  - Input fire and output fire: `out_data` ← `in_data`, stay in BUSY.
  - Input fire only: skid ← `in_data`, go to FULL.
  - Output fire only: `out_valid` ← 0, go to EMPTY.
  - Neither: hold.
- FULL:
  - `in_ready` is 0, so no input fire is possible.
  - Output fire: `out_data` ← skid, go to BUSY.
  - Otherwise hold. `out_data` must remain stable while `out_valid & !out_ready`.
- Registered outputs:
  - `in_ready` is registered as (next state != FULL).
  - `level` is registered to match the next state.
- Latency and throughput:
  - A word accepted at edge N appears on `out_data`/`out_valid` after edge N if the buffer was EMPTY.
  - With `out_ready` held at 1, sustained throughput is one word per cycle.
- Ordering: strict FIFO order. No word is duplicated, and no word is lost except by reset or flush.
- `in_valid` while `in_ready` = 0: the word is not captured. The producer must hold it; no overflow is possible.
- `out_ready` while `out_valid` = 0: no effect.
- `FLUSH_EN == 0`: `flush` has no effect.

Test Plan:
- Reset then stream:
  - Stimulus: hold `rst` = 0 for 2 cycles, release, drive `in_valid` = 1 with 0x000000000001, 0x000000000002, 0x000000000003 on consecutive cycles, `out_ready` = 1.
  - Required response: after reset `out_valid` = 0, `in_ready` = 1, `level` = 0. `out_data` shows 1, 2, 3 on consecutive cycles, each one cycle after acceptance, with `level` = 1 throughout.
- Stall and skid:
  - Stimulus: `out_ready` = 0, push 0xAAAA_AAAA_AAAA then 0x5555_5555_5555.
  - Required response: `level` reaches 2 and `in_ready` drops to 0 the cycle after the second accept. `out_data` holds 0xAAAA_AAAA_AAAA. A third word offered is not accepted.
- Drain from FULL:
  - Stimulus: from the previous state, raise `out_ready` for 2 cycles with `in_valid` = 0.
  - Required response: `out_data` shows 0xAAAA_AAAA_AAAA then 0x5555_5555_5555. `level` goes 2→1→0, `in_ready` returns to 1, and `out_valid` falls after the second fire.
- Simultaneous in/out in BUSY:
  - Stimulus: `level` = 1 with 0x10, then `in_valid` = 1 with 0x11 and `out_ready` = 1 in the same cycle.
  - Required response: `out_data` becomes 0x11, `level` stays 1, and `in_ready` stays 1.
- Flush versus handshake:
  - Stimulus: in FULL, assert `flush` = 1 together with `out_ready` = 1.
  - Required response: next cycle `level` = 0, `out_valid` = 0, `in_ready` = 1, and no word is delivered. Repeat with `FLUSH_EN` = 0: a normal drain occurs.
- Reset mid-operation:
  - Stimulus: in FULL, pull `rst` = 0 for one cycle while `in_valid` = 1.
  - Required response: `out_valid` = 0, `out_data` = 0, `level` = 0. The offered word is not captured.
